// File: rtl/branch_wb_collect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_wb_collect_pkg
// Description : Shared types and the ROB-index age compare used by the
//               branch writeback collector.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_wb_collect_pkg;

    localparam int ROB_IDX_W = 5;
    localparam int FTQ_IDX_W = 4;
    localparam int PC_W      = 32;

    typedef struct packed {
        logic                 flag;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef struct packed {
        robIdx_t              rob_idx;
        logic [FTQ_IDX_W-1:0] ftq_idx;
        logic                 has_mispred;
        logic                 taken;
        logic [PC_W-1:0]      target;
    } branchwbInfo_t;

    typedef struct packed {
        logic [PC_W-1:0] redirect_pc;
        logic            is_exception;
    } squashInfo_t;

    typedef struct packed {
        branchwbInfo_t info;
        logic          kill;
    } brwbEntry_t;

    // True when a is older than b; the flag bit disambiguates ROB wrap.
    function automatic logic older(input robIdx_t a, input robIdx_t b);
        if (a.flag == b.flag) begin
            return (a.idx < b.idx);
        end
        return (a.idx > b.idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/robidx_oldest_sel.sv
`default_nettype none
// ============================================================================
// Module      : robidx_oldest_sel
// Description : N-way oldest-ROB-index selector with a valid mask; lowest
//               port wins on equal age.
// Revision    : 1.0 - initial release
// ============================================================================
module robidx_oldest_sel
    import branch_wb_collect_pkg::*;
#(
    parameter int N     = 2,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_vld,
    input  robIdx_t [N-1:0] i_rob_idx,
    output logic            o_vld,
    output logic [SEL_W-1:0] o_sel,
    output robIdx_t         o_rob_idx
);

    always_comb begin
        o_vld     = 1'b0;
        o_sel     = '0;
        o_rob_idx = '0;
        for (int p = 0; p < N; p++) begin
            // strict compare keeps the earlier port on a tie
            if (i_vld[p] && (!o_vld || older(i_rob_idx[p], o_rob_idx))) begin
                o_vld     = 1'b1;
                o_sel     = SEL_W'(p);
                o_rob_idx = i_rob_idx[p];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_wb_collect.sv
`default_nettype none
// ============================================================================
// Module      : branch_wb_collect
// Description : In-order buffer of branch writebacks for FTQ training, with
//               squash filtering and oldest-mispredict tracking.
//               Option macro: BRWB_MISPRED_BYPASS_EN (0-latency mispredict).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_wb_collect
    import branch_wb_collect_pkg::*;
#(
    parameter int NUM_BRU    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_BRU-1:0]           i_wb_vld,
    input  branchwbInfo_t [NUM_BRU-1:0]  i_wb_info,
    output logic                         o_wb_rdy,
    output logic                         o_ftq_vld,
    output branchwbInfo_t                o_ftq_info,
    input  logic                         i_ftq_rdy,
    output logic                         o_mispred_vld,
    output branchwbInfo_t                o_mispred_info,
    input  logic                         i_squash_vld,
    input  squashInfo_t                  i_squash_info,
    input  robIdx_t                      i_squash_robIdx
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int SEL_W = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1;

    brwbEntry_t         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic               r_misp_vld;
    branchwbInfo_t      r_misp_info;

    logic [PTR_W-1:0]   w_count;
    logic [PTR_W-1:0]   w_enq_cnt;
    logic [IDX_W-1:0]   w_slot [NUM_BRU];
    logic               w_empty;
    logic               w_pop;
    brwbEntry_t         w_head;

    logic [NUM_BRU-1:0] w_cand_mask;
    robIdx_t [NUM_BRU-1:0] w_cand_rob;
    logic               w_cand_vld;
    logic [SEL_W-1:0]   w_cand_sel;
    robIdx_t            w_cand_rob_sel;
    branchwbInfo_t      w_cand_info;
    logic               w_cand_take;
    logic               w_unused_squash_info;

    // ------------------------------------------------------------------
    // FIFO status and head view
    // ------------------------------------------------------------------
    assign w_head     = r_mem[r_head[IDX_W-1:0]];
    assign w_empty    = (r_head == r_tail);
    assign w_count    = r_tail - r_head;
    assign w_pop      = !w_empty && (w_head.kill || i_ftq_rdy);
    assign o_ftq_vld  = !w_empty && !w_head.kill;
    assign o_ftq_info = w_head.info;
    assign o_wb_rdy   = (w_count <= PTR_W'(FIFO_DEPTH - NUM_BRU));

    // Compact valid ports, in port order, onto consecutive tail slots.
    always_comb begin
        w_enq_cnt = '0;
        for (int p = 0; p < NUM_BRU; p++) begin
            w_slot[p] = r_tail[IDX_W-1:0] + w_enq_cnt[IDX_W-1:0];
            if (i_wb_vld[p]) begin
                w_enq_cnt = w_enq_cnt + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_squash_vld) begin
            // Marking stale slots too is harmless: enqueue clears kill.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (older(i_squash_robIdx, r_mem[i].info.rob_idx)) begin
                    r_mem[i].kill <= 1'b1;
                end
            end
        end else begin
            for (int p = 0; p < NUM_BRU; p++) begin
                if (i_wb_vld[p]) begin
                    r_mem[w_slot[p]].info <= i_wb_info[p];
                    r_mem[w_slot[p]].kill <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + {{(PTR_W-1){1'b0}}, w_pop};
            if (!i_squash_vld) begin
                r_tail <= r_tail + w_enq_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Oldest mispredict tracking
    // ------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NUM_BRU; p++) begin
            w_cand_mask[p] = i_wb_vld[p] && i_wb_info[p].has_mispred;
            w_cand_rob[p]  = i_wb_info[p].rob_idx;
        end
    end

    robidx_oldest_sel #(
        .N     (NUM_BRU),
        .SEL_W (SEL_W)
    ) u_misp_sel (
        .i_vld     (w_cand_mask),
        .i_rob_idx (w_cand_rob),
        .o_vld     (w_cand_vld),
        .o_sel     (w_cand_sel),
        .o_rob_idx (w_cand_rob_sel)
    );

    assign w_cand_info = i_wb_info[w_cand_sel];
    assign w_cand_take = w_cand_vld &&
                         (!r_misp_vld || older(w_cand_rob_sel, r_misp_info.rob_idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misp_vld  <= 1'b0;
            r_misp_info <= '0;
        end else if (i_squash_vld) begin
            r_misp_vld  <= 1'b0;
            r_misp_info <= '0;
        end else if (w_cand_take) begin
            r_misp_vld  <= 1'b1;
            r_misp_info <= w_cand_info;
        end
    end

`ifdef BRWB_MISPRED_BYPASS_EN
    assign o_mispred_vld  = !i_squash_vld && (r_misp_vld || w_cand_vld);
    assign o_mispred_info = w_cand_take ? w_cand_info : r_misp_info;
`else
    assign o_mispred_vld  = r_misp_vld;
    assign o_mispred_info = r_misp_info;
`endif

    // Squash payload is carried for downstream use; only the robIdx matters here.
    assign w_unused_squash_info = ^i_squash_info;

`ifndef SYNTHESIS
    a_wb_only_when_rdy: assert property (@(posedge clk) disable iff (rst)
        (|i_wb_vld) |-> o_wb_rdy);
`endif

endmodule
`default_nettype wire
